// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator for the CPU load/store path.
// Ports: clk_i/rst_i (async active-high); req_* request in, req_ready_o;
//   rsp_valid_o/rsp_err_o/rsp_rdata_o completion pulse; Wishbone cyc_o,
//   stb_o, we_o, adr_o, sel_o, dat_o out and dat_i, ack_i, err_i, rty_i in.
// Optional feature: define WB_TIMEOUT_EN to abort ACTIVE after
//   TIMEOUT_CYCLES cycles with no termination (error response).
module wb_initiator #(
   parameter int RETRY_LIMIT    = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic        rsp_err_o,
   output logic [31:0] rsp_rdata_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] adr_o,
   output logic [3:0]  sel_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic        rty_i
);

   typedef enum logic [2:0] {
      IDLE, CHECK, ACTIVE, BACKOFF, RESP
   } state_t;

   localparam int RW = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

   state_t        state_q;
   logic [31:0]   req_addr_q;
   logic [31:0]   req_wdata_q;
   logic [1:0]    req_size_q;
   logic          req_we_q;
   logic          req_uns_q;
   logic [RW-1:0] rty_cnt_q;

   logic          cyc_q;
   logic          stb_q;
   logic          bwe_q;
   logic [31:0]   adr_q;
   logic [3:0]    sel_q;
   logic [31:0]   dat_q;
   logic          rsp_valid_q;
   logic          rsp_err_q;
   logic [31:0]   rsp_rdata_q;

   logic          legal_d;
   logic [3:0]    sel_d;
   logic [31:0]   dat_d;
   logic [31:0]   shifted;
   logic [31:0]   rdata_d;
   logic          tmo_hit;

`ifdef WB_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q;
   // Hit on the last silent cycle so strobe lasts exactly TIMEOUT_CYCLES.
   assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES != 0);
   assign tmo_hit    = 1'b0;
`endif

   assign req_ready_o = (state_q == IDLE) & ~rst_i;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign cyc_o       = cyc_q;
   assign stb_o       = stb_q;
   assign we_o        = bwe_q;
   assign adr_o       = adr_q;
   assign sel_o       = sel_q;
   assign dat_o       = dat_q;

   // Lane selects, replicated store data and alignment legality.
   always_comb begin
      legal_d = 1'b0;
      sel_d   = 4'b0000;
      dat_d   = req_wdata_q;
      unique case (req_size_q)
         2'b00: begin
            legal_d = 1'b1;
            sel_d   = 4'b0001 << req_addr_q[1:0];
            dat_d   = {4{req_wdata_q[7:0]}};
         end
         2'b01: begin
            legal_d = ~req_addr_q[0];
            sel_d   = 4'b0011 << req_addr_q[1:0];
            dat_d   = {2{req_wdata_q[15:0]}};
         end
         2'b10: begin
            legal_d = (req_addr_q[1:0] == 2'b00);
            sel_d   = 4'b1111;
         end
         default: ;
      endcase
   end

   // Load alignment and sign/zero extension.
   assign shifted = dat_i >> {req_addr_q[1:0], 3'b000};

   always_comb begin
      rdata_d = shifted;
      unique case (req_size_q)
         2'b00:   rdata_d = {{24{shifted[7] & ~req_uns_q}}, shifted[7:0]};
         2'b01:   rdata_d = {{16{shifted[15] & ~req_uns_q}}, shifted[15:0]};
         default: ;
      endcase
      if (req_we_q) rdata_d = '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_size_q  <= '0;
         req_we_q    <= 1'b0;
         req_uns_q   <= 1'b0;
         rty_cnt_q   <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         bwe_q       <= 1'b0;
         adr_q       <= '0;
         sel_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef WB_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  req_addr_q  <= req_addr_i;
                  req_wdata_q <= req_wdata_i;
                  req_size_q  <= req_size_i;
                  req_we_q    <= req_we_i;
                  req_uns_q   <= req_unsigned_i;
                  rty_cnt_q   <= '0;
                  state_q     <= CHECK;
               end
            end
            CHECK: begin
               if (legal_d) begin
                  state_q <= ACTIVE;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  bwe_q   <= req_we_q;
                  adr_q   <= {req_addr_q[31:2], 2'b00};
                  sel_q   <= sel_d;
                  dat_q   <= dat_d;
`ifdef WB_TIMEOUT_EN
                  tmo_q   <= '0;
`endif
               end else begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
               end
            end
            ACTIVE: begin
               if (err_i ||
                   (rty_i && rty_cnt_q == RW'(RETRY_LIMIT)) ||
                   (!rty_i && !ack_i && tmo_hit)) begin
                  state_q     <= RESP;
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
               end else if (rty_i) begin
                  state_q   <= BACKOFF;
                  cyc_q     <= 1'b0;
                  stb_q     <= 1'b0;
                  rty_cnt_q <= rty_cnt_q + 1'b1;
               end else if (ack_i) begin
                  state_q     <= RESP;
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= rdata_d;
               end
`ifdef WB_TIMEOUT_EN
               else begin
                  tmo_q <= tmo_q + 1'b1;
               end
`endif
            end
            BACKOFF: begin
               // Re-strobe with the bus fields still held from CHECK.
               state_q <= ACTIVE;
               cyc_q   <= 1'b1;
               stb_q   <= 1'b1;
`ifdef WB_TIMEOUT_EN
               tmo_q   <= '0;
`endif
            end
            RESP: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_initiator.sv
// Scoreboard bench for wb_initiator: randomized requests, a behavioural
// responder, and a reference model of responses, bus fields and latency.
module tb_wb_initiator;

   localparam int RL = 3;
`ifdef WB_TIMEOUT_EN
   localparam int TMO    = 8;
   localparam bit TMO_EN = 1'b1;
`else
   localparam int TMO    = 255;
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_addr_i = '0;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = '0;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic        rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [31:0] adr_o;
   logic [3:0]  sel_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i = '0;
   logic        ack_i = 1'b0;
   logic        err_i = 1'b0;
   logic        rty_i = 1'b0;

   wb_initiator #(.RETRY_LIMIT(RL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
      .rsp_rdata_o(rsp_rdata_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
      .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o),
      .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc_cnt = 0;
   always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

   // kind: 0 ack, 1 err, 2 err+ack together, 3 silent
   typedef struct {
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        we;
      int          n_rty;
      int          kind;
      logic        rack;
      int          lat;
      logic [31:0] rdata;
   } bus_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   bus_t bus_q[$];
   exp_t exp_q[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: got event expected none", nm);
   endtask

   // Responder: drives terminations at negedge, checks each strobe.
   initial begin : responder
      int   scnt;
      int   att;
      bit   fin;
      bit   isr;
      bus_t b;
      scnt = 0; att = 0; fin = 0; isr = 0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            ack_i = 0; err_i = 0; rty_i = 0;
            scnt = 0; att = 0; fin = 0;
            bus_q.delete();
         end else if (cyc_o && stb_o) begin
            scnt++;
            if (bus_q.size() == 0) begin
               if (scnt == 1) flag("unexpected_strobe");
            end else begin
               b = bus_q[0];
               if (scnt == 1) begin
                  check("bus_adr", adr_o, b.adr);
                  check("bus_sel", {28'd0, sel_o}, {28'd0, b.sel});
                  check("bus_we", {31'd0, we_o}, {31'd0, b.we});
                  if (b.we) check("bus_dat", dat_o, b.dat);
                  isr = (att < b.n_rty);
                  fin = (att == RL) || !isr;
               end
               if (scnt == b.lat + 1) begin
                  dat_i = b.rdata;
                  if (isr) begin
                     rty_i = 1; ack_i = b.rack;
                  end else begin
                     ack_i = (b.kind == 0 || b.kind == 2);
                     err_i = (b.kind == 1 || b.kind == 2);
                  end
               end
            end
         end else begin
            ack_i = 0; err_i = 0; rty_i = 0;
            dat_i = $urandom;
            if (scnt > 0 && bus_q.size() != 0) begin
               if (fin) begin
                  void'(bus_q.pop_front());
                  att = 0;
               end else begin
                  att++;
               end
            end
            scnt = 0; fin = 0;
         end
      end
   end

   // Monitor: pops the scoreboard on every response pulse.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
               flag("unexpected_rsp");
            end else begin
               e = exp_q.pop_front();
               check("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
               check("rsp_rdata", rsp_rdata_o, e.rdata);
               check("rsp_cycle", cyc_cnt, e.cyc);
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [1:0] sz,
                        input logic we, input logic uns,
                        input logic [31:0] wd, input int nr,
                        input int kind, input logic rack, input int lat,
                        input logic [31:0] rd);
      bus_t        b;
      exp_t        e;
      int          n, bytes, idx, nb, att, g;
      bit          legal, silent;
      logic [31:0] v;
      @(negedge clk_i);
      req_valid_i = 1; req_addr_i = a; req_size_i = sz;
      req_we_i = we; req_unsigned_i = uns; req_wdata_i = wd;
      g = 0;
      while (!req_ready_o && g < 300) begin
         @(negedge clk_i);
         g++;
      end
      if (!req_ready_o) begin
         flag("accept_timeout");
         req_valid_i = 0;
         return;
      end
      n     = cyc_cnt;
      bytes = 1 << sz;
      idx   = int'(a[1:0]);
      legal = (sz != 2'b11) && (idx % bytes == 0);
      if (!legal) begin
         e.err = 1; e.rdata = '0; e.cyc = n + 2;
         exp_q.push_back(e);
      end else begin
         b.adr   = a & 32'hFFFF_FFFC;
         b.sel   = (sz == 2) ? 4'hF : 4'((sz == 0 ? 1 : 3) << idx);
         b.dat   = (sz == 0) ? wd[7:0] * 32'h0101_0101 :
                   (sz == 1) ? wd[15:0] * 32'h0001_0001 : wd;
         b.we    = we;
         b.n_rty = nr; b.kind = kind; b.rack = rack;
         b.lat   = lat; b.rdata = rd;
         bus_q.push_back(b);
         silent = 0;
         if (nr > RL) begin
            att = RL + 1; e.err = 1;
         end else begin
            att    = nr + 1;
            e.err  = (kind != 0);
            silent = (kind == 3);
         end
         v = rd >> (8 * idx);
         nb = 8 * bytes;
         if (nb < 32) begin
            v = v & ((32'd1 << nb) - 1);
            if (!uns && v[nb-1]) v = v - (32'd1 << nb);
         end
         e.rdata = (we || e.err) ? 32'd0 : v;
         e.cyc = n + 2 + (att - 1) * (lat + 2) + (silent ? TMO : lat + 1);
         if (!silent || TMO_EN) exp_q.push_back(e);
      end
      @(negedge clk_i);
      req_valid_i = 0;
      req_addr_i = $urandom; req_wdata_i = $urandom;
      req_size_i = 2'($urandom); req_we_i = 1'($urandom);
      req_unsigned_i = 1'($urandom);
   endtask

   task automatic reset_mid();
      int g;
      g = 0;
      while (!cyc_o && g < 50) begin
         @(negedge clk_i);
         g++;
      end
      check("reset_saw_cyc", {31'd0, cyc_o}, 32'd1);
      #1 rst_i = 1;
      #1 check("reset_async_cyc", {30'd0, cyc_o, stb_o}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk_i);
      #1 rst_i = 0;
      repeat (3) @(negedge clk_i);
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1);
   end

   initial begin : stim
      int hi, g, kk;
      logic [31:0] a;
      logic [1:0]  sz;
      repeat (3) @(negedge clk_i);
      check("reset_ctrl",
            {26'd0, req_ready_o, rsp_valid_o, rsp_err_o, cyc_o, stb_o, we_o},
            32'd0);
      check("reset_rdata", rsp_rdata_o, 32'd0);
      check("reset_adr", adr_o, 32'd0);
      check("reset_sel", {28'd0, sel_o}, 32'd0);
      check("reset_dat", dat_o, 32'd0);
      #1 rst_i = 0;
      @(negedge clk_i);
      check("ready_after_reset", {31'd0, req_ready_o}, 32'd1);

      issue(32'h10, 2'b10, 1, 0, 32'hDEADBEEF, 0, 0, 0, 1, 32'h0);
      issue(32'h13, 2'b00, 0, 0, 32'h0, 0, 0, 0, 1, 32'h80123456);
      issue(32'h13, 2'b00, 0, 1, 32'h0, 0, 0, 0, 1, 32'h80123456);
      issue(32'h2, 2'b01, 1, 0, 32'h00001234, 0, 0, 0, 1, 32'h0);
      issue(32'h1, 2'b01, 0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
      issue(32'h6, 2'b10, 0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
      issue(32'h8, 2'b11, 1, 0, 32'h5, 0, 0, 0, 1, 32'h0);
      issue(32'h20, 2'b10, 0, 0, 32'h0, 3, 0, 0, 0, 32'hCAFEF00D);
      issue(32'h24, 2'b10, 0, 0, 32'h0, 4, 0, 0, 0, 32'h1);
      issue(32'h28, 2'b10, 0, 0, 32'h0, 0, 2, 0, 1, 32'h12345678);
      issue(32'h2E, 2'b01, 0, 0, 32'h0, 1, 0, 1, 2, 32'h8001_7FFF);

      issue(32'h40, 2'b10, 0, 0, 32'h0, 0, 3, 0, 0, 32'h0);
      if (!TMO_EN) begin
         hi = 0;
         repeat (1000) begin
            @(negedge clk_i);
            if (cyc_o && stb_o) hi++;
         end
         check("silent_hold", hi, 1000);
         reset_mid();
      end

      issue(32'h50, 2'b10, 0, 0, 32'h0, 2, 0, 0, 2, 32'h0);
      reset_mid();

      for (int i = 0; i < 250; i++) begin
         a  = $urandom;
         sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 2) != 0 && sz != 2'b11)
            a = a & ~((32'd1 << sz) - 1);
         kk = $urandom_range(0, 7);
         issue(a, sz, 1'($urandom), 1'($urandom), $urandom,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
               (kk < 6) ? 0 : kk - 5, 1'($urandom),
               $urandom_range(0, 2), $urandom);
      end

      g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(negedge clk_i);
         g++;
      end
      check("drain", exp_q.size(), 0);
      repeat (5) @(negedge clk_i);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic single-transfer bus initiator for the CPU load/store path, driving the SoC bus that the memory and peripheral responders sit on. It accepts one load or store request at a time and generates byte-lane selects and replicated write data from size and address. It runs the cyc/stb handshake, retries on rty and reports err. Load data is aligned and sign- or zero-extended before it is returned to the core.

## Interface
- RETRY_LIMIT, 3: number of reissues after rty_i before the request completes with error.
- TIMEOUT_CYCLES, 255: cycles without any termination before abort. Used only with WB_TIMEOUT_EN.
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  request accepted when req_valid_i & req_ready_o.
- req_addr_i  input  32  byte address.
- req_we_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned_i  input  1  zero-extend the load result (1) or sign-extend it (0).
- req_wdata_i  input  32  store data, right-aligned.
- rsp_valid_o  output  1  one-cycle completion pulse.
- rsp_err_o  output  1  completion was an error; valid with rsp_valid_o.
- rsp_rdata_o  output  32  extended load data; 0 for stores and errors.
- cyc_o, stb_o, we_o  output  1 each  Wishbone cycle, strobe, write enable.
- adr_o  output  32  word address {req_addr_i[31:2], 2'b00}.
- sel_o  output  4  byte lanes.
- dat_o  output  32  write data.
- dat_i  input  32  read data; sampled only when ack_i=1.
- ack_i, err_i, rty_i  input  1 each  termination signals.

## Operation
- States:
  - IDLE: req_ready_o = !rst_i.
  - CHECK: entered on the accepted request.
  - ACTIVE: cyc_o = stb_o = 1.
  - BACKOFF: cyc_o = stb_o = 0 for one cycle.
  - RESP: rsp_valid_o = 1 for one cycle.
- Address, size, we, unsigned and wdata are registered at acceptance; the core may change its inputs afterwards.
- CHECK sends an illegal request straight to RESP with rsp_err_o = 1, and no bus cycle is started:
  - req_size_i = 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0.
- CHECK sends a legal request to ACTIVE.
- Byte lanes:
  - byte: sel_o = 0001 << addr[1:0]; dat_o = {4{wdata[7:0]}}.
  - halfword: sel_o = 0011 << addr[1:0]; dat_o = {2{wdata[15:0]}}.
  - word: sel_o = 1111; dat_o = wdata.
- Load data: dat_i is shifted right by 8*addr[1:0], then bits above the access size are filled with the access MSB (signed) or with zero (unsigned).
- In ACTIVE, termination priority when several are sampled high together is err_i > rty_i > ack_i:
  - err_i → RESP, rsp_err_o = 1, rsp_rdata_o = 0.
  - rty_i with retry count < RETRY_LIMIT → BACKOFF, count + 1, then ACTIVE with identical adr/sel/dat/we.
  - rty_i with count = RETRY_LIMIT → RESP with error.
  - ack_i → RESP, rsp_err_o = 0, rsp_rdata_o = extended data (0 for stores).
- Retry count clears on every acceptance.
- RESP → IDLE.
- cyc_o/stb_o drop in the cycle after a termination is sampled, so the initiator never issues back-to-back strobes to a responder that is still acknowledging.

## Timing
- Every output is 0 in reset, including req_ready_o.
- Asserting rst_i mid-transfer clears cyc_o/stb_o immediately, without waiting for a clock edge. State returns to IDLE and no response is produced.
- Handshake in cycle N: CHECK in N+1, ACTIVE from N+2.
- With a responder that acks one cycle after strobe (ack high in N+3), rsp_valid_o is high in N+4 and req_ready_o is high again in N+5.
- Misaligned or illegal request: rsp_valid_o is high in N+2, and cyc_o never rises.
- Each rty adds 2 cycles (BACKOFF plus re-strobe) beyond the responder's own latency.
- rsp_valid_o is exactly one cycle wide; there is no response backpressure.

## Configuration
- WB_TIMEOUT_EN defined:
  - A counter clears on entering ACTIVE and increments each ACTIVE cycle with no termination sampled.
  - When it reaches TIMEOUT_CYCLES: cyc_o/stb_o drop, then RESP with rsp_err_o = 1.
  - A termination sampled in the same cycle as the timeout wins.
- WB_TIMEOUT_EN undefined: the counter is not built and ACTIVE waits indefinitely. TIMEOUT_CYCLES is ignored.

## Test plan
- Word store 0xDEADBEEF to 0x0000_0010, responder acks after 1 cycle → adr_o=0x10, sel_o=1111, we_o=1, one-cycle stb. rsp_valid_o at N+4 with err=0, rdata=0.
- Byte load signed at 0x13, responder returns dat_i=0x80xx_xxxx → sel_o=1000, rsp_rdata_o=0xFFFF_FF80. Repeat unsigned → 0x0000_0080.
- Halfword store 0x1234 at 0x2 → sel_o=1100, dat_o=0x1234_1234. Halfword load at 0x1 → no cyc_o, rsp_valid_o at N+2 with err=1.
- Responder asserts rty_i 3 times then ack_i, RETRY_LIMIT=3 → 4 strobes, each separated by one idle cycle, err=0. With 4 rty → err=1 after 4 strobes.
- err_i and ack_i sampled high together → rsp_err_o=1, rsp_rdata_o=0. Reset pulse during ACTIVE → cyc_o low before the next clock edge, no rsp_valid_o.
- With WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, silent responder → stb_o high 8 cycles, then rsp_valid_o with err=1. Without the macro → cyc_o stays high for 1000 cycles.
